// File: rtl/dmem_access_sequencer.sv
// -----------------------------------------------------------------------------
// dmem_access_sequencer
//
// Processor-side initiator for a word-wide data memory. The memory has no byte
// enables and one cycle of read latency. Each load/store request is turned into
// a short sequence of word reads and writes:
//   - aligned word store      : one write
//   - loads                   : one read, or two for a word-crossing access
//   - sub-word / misaligned st: read-modify-write, over two words when crossing
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  request handshake; ready is high only when idle
//   req_wr           1 = store, 0 = load
//   req_unsigned     load zero-extends when 1, sign-extends when 0
//   req_width        2'b10 byte, 2'b01 half, 2'b00/2'b11 word
//   req_addr         byte address, bits [16:0] used, little-endian
//   req_wdata        store data (low byte/half used for sub-word stores)
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data, 0 for stores
//   mem_addr         word index
//   mem_rden/wren    memory read / write enables (never both high)
//   mem_wdata        memory write data
//   mem_rdata        memory read data, valid the cycle after mem_rden
// -----------------------------------------------------------------------------
module dmem_access_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_unsigned,
  input  logic [1:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [14:0] mem_addr,
  output logic        mem_rden,
  output logic        mem_wren,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CAP  = 3'd3,
    S_WR0  = 3'd4,
    S_WR1  = 3'd5,
    S_RESP = 3'd6
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state_reg, state_next;

  // Request fields captured at accept; never re-sampled afterwards.
  logic        wr_reg;
  logic        unsigned_reg;
  logic        cross_reg;
  logic [1:0]  size_reg;
  logic [1:0]  off_reg;
  logic [14:0] w0_reg;
  logic [14:0] w1_reg;
  logic [7:0]  lane_mask_reg;   // byte lanes of {word1,word0} touched by a store
  logic [63:0] wdata_sh_reg;    // store data already moved onto its lanes

  // Memory words fetched during the read phase and the load result.
  logic [31:0] word0_reg;
  logic [31:0] word1_reg;
  logic [31:0] rdata_reg;

  // ---------------------------------------------------------------------------
  // Request decode (only consumed on the accept cycle)
  // ---------------------------------------------------------------------------
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic [14:0] req_w0;
  logic [3:0]  req_base_mask;
  logic [7:0]  req_lane_mask;
  logic [63:0] req_wdata_sh;
  logic        req_cross;
  logic        req_aligned_sw;
  logic        accept;
  logic        unused_addr_bits;

  always_comb begin
    req_off = req_addr[1:0];
    req_w0  = req_addr[16:2];
    case (req_width)
      2'b10: begin
        req_size      = SZ_BYTE;
        req_base_mask = 4'b0001;
      end
      2'b01: begin
        req_size      = SZ_HALF;
        req_base_mask = 4'b0011;
      end
      default: begin
        req_size      = SZ_WORD;
        req_base_mask = 4'b1111;
      end
    endcase
    // Bytes never cross; halves only from offset 3; words from any non-zero offset.
    req_cross      = ((req_size == SZ_HALF) && (req_off == 2'd3)) ||
                     ((req_size == SZ_WORD) && (req_off != 2'd0));
    req_aligned_sw = req_wr && (req_size == SZ_WORD) && (req_off == 2'd0);
    req_lane_mask  = {4'b0000, req_base_mask} << req_off;
    req_wdata_sh   = {32'h0000_0000, req_wdata} << {req_off, 3'b000};
  end

  assign accept           = req_valid && (state_reg == S_IDLE);
  assign unused_addr_bits = ^req_addr[31:17];

  // ---------------------------------------------------------------------------
  // Store merge: each byte lane of the two-word window takes either the store
  // byte or the byte read back from memory. For an aligned word store all four
  // low lanes come from req_wdata, so the (unread) old word does not matter.
  // ---------------------------------------------------------------------------
  logic [63:0] pair_old;
  logic [63:0] pair_merged;

  assign pair_old = {word1_reg, word0_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign pair_merged[8*gi +: 8] = lane_mask_reg[gi] ? wdata_sh_reg[8*gi +: 8]
                                                        : pair_old[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load extraction, evaluated in CAP where the last word is on mem_rdata.
  // For a non-crossing access the high word is never reached by the shift.
  // ---------------------------------------------------------------------------
  logic [31:0] load_lo;
  logic [31:0] load_hi;
  logic [31:0] load_shift;
  logic [31:0] load_result;

  always_comb begin
    load_lo    = cross_reg ? word0_reg : mem_rdata;
    load_hi    = cross_reg ? mem_rdata : 32'h0000_0000;
    load_shift = 32'({load_hi, load_lo} >> {off_reg, 3'b000});
    case (size_reg)
      SZ_BYTE: load_result = {{24{~unsigned_reg & load_shift[7]}},  load_shift[7:0]};
      SZ_HALF: load_result = {{16{~unsigned_reg & load_shift[15]}}, load_shift[15:0]};
      default: load_result = load_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and memory-side outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    mem_addr   = 15'd0;
    mem_rden   = 1'b0;
    mem_wren   = 1'b0;
    mem_wdata  = 32'h0000_0000;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = req_aligned_sw ? S_WR0 : S_RD0;
        end
      end
      S_RD0: begin
        mem_rden   = 1'b1;
        mem_addr   = w0_reg;
        state_next = cross_reg ? S_RD1 : S_CAP;
      end
      S_RD1: begin
        mem_rden   = 1'b1;
        mem_addr   = w1_reg;
        state_next = S_CAP;
      end
      S_CAP: begin
        state_next = wr_reg ? S_WR0 : S_RESP;
      end
      S_WR0: begin
        mem_wren   = 1'b1;
        mem_addr   = w0_reg;
        mem_wdata  = pair_merged[31:0];
        state_next = cross_reg ? S_WR1 : S_RESP;
      end
      S_WR1: begin
        mem_wren   = 1'b1;
        mem_addr   = w1_reg;
        mem_wdata  = pair_merged[63:32];
        state_next = S_RESP;
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      wr_reg        <= 1'b0;
      unsigned_reg  <= 1'b0;
      cross_reg     <= 1'b0;
      size_reg      <= SZ_BYTE;
      off_reg       <= 2'd0;
      w0_reg        <= 15'd0;
      w1_reg        <= 15'd0;
      lane_mask_reg <= 8'h00;
      wdata_sh_reg  <= 64'h0;
      word0_reg     <= 32'h0000_0000;
      word1_reg     <= 32'h0000_0000;
      rdata_reg     <= 32'h0000_0000;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        wr_reg        <= req_wr;
        unsigned_reg  <= req_unsigned;
        cross_reg     <= req_cross;
        size_reg      <= req_size;
        off_reg       <= req_off;
        w0_reg        <= req_w0;
        w1_reg        <= req_w0 + 15'd1;   // wraps 0x7FFF -> 0x0000
        lane_mask_reg <= req_lane_mask;
        wdata_sh_reg  <= req_wdata_sh;
        rdata_reg     <= 32'h0000_0000;    // stores respond with zero data
      end

      // RD1 sees the data requested in RD0.
      if (state_reg == S_RD1) begin
        word0_reg <= mem_rdata;
      end

      // CAP sees the data of the last read issued.
      if (state_reg == S_CAP) begin
        if (cross_reg) begin
          word1_reg <= mem_rdata;
        end else begin
          word0_reg <= mem_rdata;
        end
        if (!wr_reg) begin
          rdata_reg <= load_result;
        end
      end
    end
  end

  assign req_ready  = (state_reg == S_IDLE) && !rst;
  assign resp_valid = (state_reg == S_RESP);
  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_dmem_access_sequencer.sv
module tb_dmem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [14:0] mem_addr;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_access_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_unsigned (req_unsigned),
    .req_width    (req_width),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Data memory model: word-wide, no byte enables, one cycle read latency.
  logic [31:0] mem [0:32767];
  logic        preload_req = 1'b0;

  always @(posedge clk) begin
    if (preload_req) begin
      mem[15'h0010] <= 32'h8899AABB;
      mem[15'h0011] <= 32'h11223344;
      mem[15'h7FFF] <= 32'hCAFEF00D;
      mem[15'h0000] <= 32'h76543210;
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_rden ? mem[mem_addr] : 32'hDEADDEAD;
  end

  // Scoreboard queues: expected memory cycles and expected response.
  typedef struct {
    int          cyc;
    bit          wr;
    logic [14:0] addr;
    logic [31:0] data;
  } memop_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } resp_t;

  memop_t op_q[$];
  resp_t  resp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic exp_rd(input int c, input logic [14:0] a);
    op_q.push_back('{cyc: c, wr: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic exp_wr(input int c, input logic [14:0] a, input logic [31:0] d);
    op_q.push_back('{cyc: c, wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_resp(input int c, input logic [31:0] d);
    resp_q.push_back('{cyc: c, data: d});
  endtask

  task automatic preload();
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  // Issue one request and follow it cycle by cycle, comparing every memory
  // cycle and the response against the queued expectations. With noise set,
  // req_valid stays high with a different request while the block is busy.
  task automatic exec(input string name, input bit wr, input bit uns,
                      input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input bit noise);
    int     k;
    bit     done;
    memop_t op;
    resp_t  r;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s ready_wait: req_ready=%b required 1", name, req_ready);
    else passes++;

    req_wr = wr; req_unsigned = uns; req_width = w; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      req_wr = 1'b1; req_width = 2'b00; req_addr = 32'h0000_0040; req_wdata = 32'h0;
    end else begin
      req_valid = 1'b0;
    end

    done = 1'b0;
    for (k = 1; k <= 20 && !done; k++) begin
      checks++;
      if ((mem_rden && mem_wren) || req_ready !== 1'b0 ||
          (!mem_rden && !mem_wren && (mem_addr !== 15'd0 || mem_wdata !== 32'h0)))
        $display("FAIL %s busy_ctl@%0d: rden=%b wren=%b ready=%b addr=%h wdata=%h required exclusive enables, ready 0, idle bus 0",
                 name, k, mem_rden, mem_wren, req_ready, mem_addr, mem_wdata);
      else passes++;

      if (mem_rden || mem_wren) begin
        checks++;
        if (op_q.size() == 0) begin
          $display("FAIL %s memop@%0d: unexpected wr=%b addr=%h data=%h required no cycle",
                   name, k, mem_wren, mem_addr, mem_wdata);
        end else begin
          op = op_q.pop_front();
          if (k != op.cyc || mem_wren !== op.wr || mem_addr !== op.addr || mem_wdata !== op.data)
            $display("FAIL %s memop: got cyc=%0d wr=%b addr=%h data=%h required cyc=%0d wr=%b addr=%h data=%h",
                     name, k, mem_wren, mem_addr, mem_wdata, op.cyc, op.wr, op.addr, op.data);
          else passes++;
        end
      end

      if (resp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
        checks++;
        if (resp_q.size() == 0) begin
          $display("FAIL %s resp: unexpected response data=%h", name, resp_rdata);
        end else begin
          r = resp_q.pop_front();
          if (k != r.cyc || resp_rdata !== r.data)
            $display("FAIL %s resp: got cyc=%0d data=%h required cyc=%0d data=%h",
                     name, k, resp_rdata, r.cyc, r.data);
          else passes++;
        end
      end

      if (!done) begin
        @(posedge clk); #1;
      end
    end

    if (!done) begin
      checks++;
      req_valid = 1'b0;
      $display("FAIL %s timeout: no resp_valid within 20 cycles, required one", name);
    end
    if (op_q.size() != 0) begin
      checks++;
      $display("FAIL %s missing_memops: %0d expected cycles not seen, required 0", name, op_q.size());
      op_q.delete();
    end
    resp_q.delete();

    // Cycle after RESP: idle again and ready for a back-to-back accept.
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL %s after_resp: ready=%b resp_valid=%b required ready=1 resp_valid=0",
               name, req_ready, resp_valid);
    else passes++;
    $display("txn %s: addr=%h wr=%b width=%b -> rdata=%h", name, a, wr, w, resp_rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_unsigned = 1'b0; req_width = 2'b00;
    req_addr = 32'h40; req_wdata = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_rden !== 1'b0 || mem_wren !== 1'b0 ||
        mem_addr !== 15'd0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0)
      $display("FAIL reset_state: ready=%b resp=%b rden=%b wren=%b addr=%h wdata=%h rdata=%h required all 0",
               req_ready, resp_valid, mem_rden, mem_wren, mem_addr, mem_wdata, resp_rdata);
    else passes++;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    else passes++;
    $display("txn reset: ready=%b", req_ready);
  endtask

  task automatic test_load_byte();
    preload();
    exp_rd(1, 15'h10); exp_resp(3, 32'hFFFFFFAA);
    exec("lb_signed", 1'b0, 1'b0, 2'b10, 32'h41, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_resp(3, 32'h000000AA);
    exec("lbu", 1'b0, 1'b1, 2'b10, 32'h41, 32'h0, 1'b0);
    exp_rd(1, 15'h11); exp_resp(3, 32'h00000011);
    exec("lb_positive", 1'b0, 1'b0, 2'b10, 32'h47, 32'h0, 1'b0);
  endtask

  task automatic test_load_cross();
    preload();
    exp_rd(1, 15'h10); exp_rd(2, 15'h11); exp_resp(4, 32'h22334488);
    exec("lw_cross", 1'b0, 1'b0, 2'b00, 32'h43, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_resp(3, 32'hFFFF8899);
    exec("lh_signed", 1'b0, 1'b0, 2'b01, 32'h42, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_rd(2, 15'h11); exp_resp(4, 32'h00004488);
    exec("lhu_cross", 1'b0, 1'b1, 2'b01, 32'h43, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_resp(3, 32'h8899AABB);
    exec("lw_width3", 1'b0, 1'b0, 2'b11, 32'h40, 32'h0, 1'b0);
  endtask

  task automatic test_store_subword();
    preload();
    exp_rd(1, 15'h10); exp_wr(3, 15'h10, 32'h885AAABB); exp_resp(4, 32'h0);
    exec("sb", 1'b1, 1'b0, 2'b10, 32'h42, 32'h0000005A, 1'b0);
    exp_rd(1, 15'h10); exp_resp(3, 32'h0000005A);
    exec("lbu_after_sb", 1'b0, 1'b1, 2'b10, 32'h42, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_wr(3, 15'h10, 32'h885A1234); exp_resp(4, 32'h0);
    exec("sh_aligned", 1'b1, 1'b0, 2'b01, 32'h40, 32'hFFFF1234, 1'b0);
  endtask

  task automatic test_store_cross();
    preload();
    exp_rd(1, 15'h10); exp_rd(2, 15'h11);
    exp_wr(4, 15'h10, 32'hEF99AABB); exp_wr(5, 15'h11, 32'h112233BE); exp_resp(6, 32'h0);
    exec("sh_cross", 1'b1, 1'b0, 2'b01, 32'h43, 32'h0000BEEF, 1'b0);
    exp_rd(1, 15'h10); exp_rd(2, 15'h11); exp_resp(4, 32'h2233BEEF);
    exec("lw_after_sh", 1'b0, 1'b0, 2'b00, 32'h43, 32'h0, 1'b0);
  endtask

  task automatic test_store_word();
    preload();
    exp_wr(1, 15'h11, 32'hDEADBEEF); exp_resp(2, 32'h0);
    exec("sw_aligned", 1'b1, 1'b0, 2'b00, 32'h44, 32'hDEADBEEF, 1'b0);
    exp_rd(1, 15'h11); exp_resp(3, 32'hDEADBEEF);
    exec("lw_after_sw", 1'b0, 1'b0, 2'b00, 32'h44, 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    preload();
    exp_rd(1, 15'h7FFF); exp_rd(2, 15'h0000); exp_resp(4, 32'h3210CAFE);
    exec("lw_wrap", 1'b0, 1'b0, 2'b00, 32'h0001FFFE, 32'h0, 1'b0);
    exp_rd(1, 15'h7FFF); exp_rd(2, 15'h0000);
    exp_wr(4, 15'h7FFF, 32'h78FEF00D); exp_wr(5, 15'h0000, 32'h76123456); exp_resp(6, 32'h0);
    exec("sw_wrap", 1'b1, 1'b0, 2'b00, 32'h0001FFFF, 32'h12345678, 1'b0);
    exp_rd(1, 15'h7FFF); exp_rd(2, 15'h0000); exp_resp(4, 32'h12345678);
    exec("lw_after_sw_wrap", 1'b0, 1'b0, 2'b00, 32'h0001FFFF, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    preload();
    exp_rd(1, 15'h10); exp_resp(3, 32'hFFFFFFBB);
    exec("lb_noise", 1'b0, 1'b0, 2'b10, 32'h40, 32'h0, 1'b1);
    exp_rd(1, 15'h11); exp_resp(3, 32'h00001122);
    exec("lh_b2b", 1'b0, 1'b0, 2'b01, 32'h46, 32'h0, 1'b0);
    exp_rd(1, 15'h10); exp_rd(2, 15'h11); exp_resp(4, 32'h22334488);
    exec("lw_b2b", 1'b0, 1'b0, 2'b00, 32'h43, 32'h0, 1'b1);
  endtask

  task automatic test_reset_midop();
    preload();
    req_wr = 1'b1; req_unsigned = 1'b0; req_width = 2'b01;
    req_addr = 32'h43; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (mem_wren !== 1'b1 || mem_addr !== 15'h10 || mem_wdata !== 32'hEF99AABB)
      $display("FAIL midop_wr0: wren=%b addr=%h data=%h required wren=1 addr=0010 data=ef99aabb",
               mem_wren, mem_addr, mem_wdata);
    else passes++;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_rden !== 1'b0 || mem_wren !== 1'b0 ||
          mem_addr !== 15'd0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0)
        $display("FAIL midop_reset: ready=%b resp=%b rden=%b wren=%b addr=%h wdata=%h rdata=%h required all 0",
                 req_ready, resp_valid, mem_rden, mem_wren, mem_addr, mem_wdata, resp_rdata);
      else passes++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || mem_wren !== 1'b0 || mem_rden !== 1'b0)
      $display("FAIL midop_release: ready=%b wren=%b rden=%b required ready=1 no memory cycle",
               req_ready, mem_wren, mem_rden);
    else passes++;
    checks++;
    if (mem[15'h10] !== 32'hEF99AABB || mem[15'h11] !== 32'h11223344)
      $display("FAIL midop_memory: w0=%h w1=%h required w0=ef99aabb w1=11223344",
               mem[15'h10], mem[15'h11]);
    else passes++;
    $display("txn reset_midop: w0=%h w1=%h", mem[15'h10], mem[15'h11]);
    exp_rd(1, 15'h11); exp_resp(3, 32'h11223344);
    exec("lw_after_reset", 1'b0, 1'b0, 2'b00, 32'h44, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_cross();
    test_store_subword();
    test_store_cross();
    test_store_word();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
